dog_extrema_detect: RTL
=======================

Name: dog_extrema_detect

Overview:
- Consumer at the far end of the DoG pixel stream.
- Takes the raster-order signed DoG samples (dog_pixel, dog_valid, done) for one WIDTH x HEIGHT frame.
- Finds strict 3x3 local maxima and minima whose magnitude meets a threshold.
- Queues each keypoint's coordinates in a small FIFO, read out with a valid/ready handshake by the downstream descriptor stage.

Parameters:
- WIDTH, 128, frame width in pixels.
- HEIGHT, 128, frame height in pixels.
- THRESH, 8, minimum |DoG| for a keypoint (unsigned, 0..256).
- FIFO_DEPTH, 16, keypoint FIFO entries (power of 2).

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- dog_pixel, input, 9, signed DoG sample, raster order.
- dog_valid, input, 1, dog_pixel valid this cycle; arbitrary gaps allowed.
- dog_done, input, 1, upstream end-of-frame pulse.
- kp_x, output, $clog2(WIDTH), keypoint column.
- kp_y, output, $clog2(HEIGHT), keypoint row.
- kp_min, output, 1, 0 = maximum, 1 = minimum.
- kp_valid, output, 1, FIFO head valid.
- kp_ready, input, 1, consumer accepts head; pop when kp_valid and kp_ready.
- kp_count, output, 16, keypoints detected this frame (saturating), including dropped ones.
- overflow_cnt, output, 8, keypoints dropped on full FIFO (saturating).
- frame_error, output, 1, sticky: dog_done arrived before WIDTH*HEIGHT samples.
- frame_done, output, 1, one-cycle pulse: frame processed and FIFO drained.

Behaviour:
- Reset values:
  - All outputs 0; FIFO empty; x/y counters 0; state S_IDLE.
  - Line buffer contents are don't-care, and no compare may use stale data.
- Reset mid-operation aborts the frame with no residual keypoints.
- Window:
  - Two WIDTH-entry line buffers plus a 3x3 register window, updated only on dog_valid.
  - When pixel (x,y) is accepted and x>=2, y>=2, the window centre is pixel (x-1,y-1).
  - Columns wrap: x resets to 0 and y increments after x=WIDTH-1.
  - A window that spans a row wrap is never evaluated; the x>=2 gating guarantees this.
- Candidate test (centre c, 8 neighbours n):
  - Maximum: c > every n (strict), and |c| >= THRESH.
  - Minimum: c < every n (strict), and |c| >= THRESH.
  - |c| is computed 10-bit, so -256 gives 256.
  - Ties (plateaus) never qualify. Border pixels (row/col 0 or last) never qualify.
- Latency:
  - Compare result is registered in the cycle after the accepting dog_valid.
  - FIFO write happens that same cycle; kp_valid rises the cycle after, if the FIFO was empty.
- FIFO:
  - Write when candidate and not full.
  - Write when full: entry dropped, overflow_cnt++ (saturate 255); kp_count still increments.
  - Simultaneous push and pop when full: the pop frees space, so the push succeeds.
  - kp_x/kp_y/kp_min must hold stable while kp_valid && !kp_ready.
- FSM:
  - S_IDLE -> S_STREAM on first dog_valid. kp_count and overflow_cnt clear on this transition; frame_error does not.
  - S_STREAM -> S_DRAIN after accepting sample WIDTH*HEIGHT-1.
  - S_STREAM -> S_DRAIN on dog_done with fewer samples; set frame_error; no further candidates.
  - S_DRAIN -> S_DONE when the compare pipeline is empty and the FIFO is empty.
  - S_DONE asserts frame_done for one cycle, -> S_IDLE with x=y=0.
  - dog_valid in S_DRAIN/S_DONE is ignored.
  - dog_done in S_IDLE/S_DRAIN is ignored.
- frame_error clears only on rst.

Decomposition:
- Shared package sift_pkg:
  - DOG_W=9 and the signed dog-pixel typedef.
  - Keypoint record typedef {x, y, is_min}.
  - FSM state enum.
- Natural sub-module: kp_fifo, a synchronous FIFO with full/empty, parameterised on entry width and depth, reusable by later SIFT stages.
- Line buffers are inferred inline as a BRAM-friendly single write / single read per valid.

Test Plan:
1. 128x128 all-zero frame, kp_ready=1 -> no kp_valid; kp_count=0; frame_done pulses once, within 3 cycles of the last dog_valid; frame_error=0.
2. Zero frame with +50 at (10,20), THRESH=8 -> exactly one keypoint x=10, y=20, kp_min=0; kp_count=1.
3. -50 at (0,5) and -50 at (127,60) -> no keypoints. -50 at (5,5) -> one keypoint, kp_min=1. +5 at (30,30) -> none (below THRESH). -256 at (40,40) -> keypoint, kp_min=1.
4. +50 at (10,20) and (11,20) (plateau) -> no keypoint. Random dog_valid gaps (~50% duty) -> results identical to gapless.
5. kp_ready=0, 20 isolated spikes (FIFO_DEPTH=16) -> 16 stored, overflow_cnt=4, kp_count=20, no frame_done. Then kp_ready=1 -> 16 entries in raster order, then frame_done.
6. rst after 5000 samples, then a full frame with one spike at (64,64) -> only that keypoint, counters restart from 0. Separately, dog_done after 1000 samples -> frame_error=1, then frame_done once the FIFO drains.

Source files
------------

// File: rtl/sift_pkg.sv
// sift_pkg: types shared by the SIFT pipeline stages.
//   DOG_W       : width of a signed DoG sample
//   dog_pix_t   : signed DoG sample
//   kp_rec_t    : keypoint record {x, y, is_min}
//   dog_state_t : frame-level FSM states of the extrema detector
//   dog_abs     : magnitude of a DoG sample, one bit wider so -256 -> 256
package sift_pkg;

    localparam int DOG_W = 9;

    // Coordinate fields are sized for the 128x128 frames this pipeline handles.
    localparam int KP_XW = 7;
    localparam int KP_YW = 7;

    typedef logic signed [DOG_W-1:0] dog_pix_t;

    typedef struct packed {
        logic [KP_XW-1:0] x;
        logic [KP_YW-1:0] y;
        logic             is_min;
    } kp_rec_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2,
        S_DONE   = 2'd3
    } dog_state_t;

    function automatic logic [DOG_W:0] dog_abs(input dog_pix_t v);
        logic signed [DOG_W:0] ext_v;
        logic        [DOG_W:0] mag_v;
        ext_v = {v[DOG_W-1], v};
        if (ext_v[DOG_W]) begin
            mag_v = -ext_v;
        end else begin
            mag_v = ext_v;
        end
        return mag_v;
    endfunction

endpackage

// File: rtl/kp_fifo.sv
// kp_fifo: synchronous FIFO with registered full/empty flags.
//   W, DEPTH        : entry width, number of entries (power of 2)
//   clk, rst        : clock, synchronous active-high reset
//   wr_en, wr_data  : push request and data; accepted when not full or
//                     when a pop happens in the same cycle
//   rd_en, rd_data  : pop request; rd_data shows the head entry
//   full, empty     : occupancy flags
module kp_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic [AW:0]   count_next_s;
    logic          full_r;
    logic          empty_r;
    logic          do_rd_s;
    logic          do_wr_s;

    assign do_rd_s = rd_en & ~empty_r;
    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign do_wr_s = wr_en & (~full_r | do_rd_s);

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_next_s = count_r;
        case ({do_wr_s, do_rd_s})
            2'b10:   count_next_s = count_r + 1'b1;
            2'b01:   count_next_s = count_r - 1'b1;
            default: count_next_s = count_r;
        endcase
    end

    // Pointers, occupancy and flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (do_wr_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (do_rd_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            count_r <= count_next_s;
            full_r  <= (count_next_s == (AW+1)'(DEPTH));
            empty_r <= (count_next_s == (AW+1)'(0));
        end
    end

    // Storage array; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (do_wr_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_ptr_r];
    assign full    = full_r;
    assign empty   = empty_r;

endmodule

// File: rtl/dog_extrema_detect.sv
// dog_extrema_detect: finds strict 3x3 local extrema in a raster DoG frame.
//   clk, rst                   : clock, synchronous active-high reset
//   dog_pixel/dog_valid        : signed DoG sample stream, gaps allowed
//   dog_done                   : upstream end-of-frame pulse
//   kp_x/kp_y/kp_min/kp_valid  : keypoint FIFO head (0 = max, 1 = min)
//   kp_ready                   : consumer pops the head when kp_valid is high
//   kp_count                   : keypoints found this frame, incl. dropped
//   overflow_cnt               : keypoints dropped on a full FIFO
//   frame_error                : sticky, frame ended short of WIDTH*HEIGHT
//   frame_done                 : one-cycle pulse, frame processed and drained
module dog_extrema_detect
    import sift_pkg::*;
#(
    parameter int WIDTH      = 128,
    parameter int HEIGHT     = 128,
    parameter int THRESH     = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [DOG_W-1:0]   dog_pixel,
    input  logic                      dog_valid,
    input  logic                      dog_done,
    output logic [$clog2(WIDTH)-1:0]  kp_x,
    output logic [$clog2(HEIGHT)-1:0] kp_y,
    output logic                      kp_min,
    output logic                      kp_valid,
    input  logic                      kp_ready,
    output logic [15:0]               kp_count,
    output logic [7:0]                overflow_cnt,
    output logic                      frame_error,
    output logic                      frame_done
);

    localparam int XW  = $clog2(WIDTH);
    localparam int YW  = $clog2(HEIGHT);
    localparam int KPW = $bits(kp_rec_t);

    dog_state_t     state_r;
    dog_state_t     state_next_s;
    logic [XW-1:0]  x_r;
    logic [YW-1:0]  y_r;
    logic [XW-1:0]  cx_r;
    logic [YW-1:0]  cy_r;
    logic           eval_r;
    logic           last_s;
    logic           abort_s;
    logic           accept_s;

    dog_pix_t       lb0_r [WIDTH];  // row y-1
    dog_pix_t       lb1_r [WIDTH];  // row y-2
    dog_pix_t       win_r [3][3];   // [row][col], row 2 / col 2 newest

    dog_pix_t       centre_s;
    logic [DOG_W:0] mag_s;
    logic           is_max_s;
    logic           is_min_s;
    logic           cand_s;

    kp_rec_t        wr_rec_s;
    kp_rec_t        head_s;
    logic [KPW-1:0] rd_data_s;
    logic           fifo_full_s;
    logic           fifo_empty_s;
    logic           pop_s;
    logic           push_s;
    logic           drop_s;

    logic [15:0]    kp_count_r;
    logic [7:0]     overflow_cnt_r;
    logic           frame_error_r;
    logic           frame_done_r;

    assign last_s  = (x_r == XW'(WIDTH-1)) && (y_r == YW'(HEIGHT-1));
    // dog_done alongside the final sample is a normal end of frame.
    assign abort_s = (state_r == S_STREAM) & dog_done & ~(dog_valid & last_s);
    assign accept_s = dog_valid &
                      ((state_r == S_IDLE) | ((state_r == S_STREAM) & ~abort_s));

    // Frame FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Frame FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (dog_valid) begin
                    state_next_s = S_STREAM;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_STREAM: begin
                if ((accept_s && last_s) || abort_s) begin
                    state_next_s = S_DRAIN;
                end else begin
                    state_next_s = S_STREAM;
                end
            end
            S_DRAIN: begin
                if (!eval_r && fifo_empty_s) begin
                    state_next_s = S_DONE;
                end else begin
                    state_next_s = S_DRAIN;
                end
            end
            S_DONE:  state_next_s = S_IDLE;
            default: state_next_s = S_IDLE;
        endcase
    end

    // Raster position of the next sample and the pending window evaluation.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_r    <= '0;
            y_r    <= '0;
            cx_r   <= '0;
            cy_r   <= '0;
            eval_r <= 1'b0;
        end else begin
            // Windows spanning a row wrap or the top two rows are never
            // evaluated, so stale line-buffer data never reaches the compare.
            eval_r <= accept_s && (x_r >= XW'(2)) && (y_r >= YW'(2));
            if (accept_s) begin
                cx_r <= x_r - 1'b1;
                cy_r <= y_r - 1'b1;
                if (x_r == XW'(WIDTH-1)) begin
                    x_r <= '0;
                    y_r <= y_r + 1'b1;
                end else begin
                    x_r <= x_r + 1'b1;
                end
            end else if (state_r == S_DONE) begin
                x_r <= '0;
                y_r <= '0;
            end
        end
    end

    // Line buffers (one read and one write per buffer per sample) and window shift.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 2; c++) begin
                    win_r[r][c] <= win_r[r][c+1];
                end
            end
            win_r[0][2]  <= lb1_r[x_r];
            win_r[1][2]  <= lb0_r[x_r];
            win_r[2][2]  <= dog_pixel;
            lb1_r[x_r]   <= lb0_r[x_r];
            lb0_r[x_r]   <= dog_pixel;
        end
    end

    // Strict extremum test of the window centre against its 8 neighbours.
    always_comb begin
        centre_s = win_r[1][1];
        is_max_s = 1'b1;
        is_min_s = 1'b1;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                is_max_s = is_max_s & ((r == 1 && c == 1) || (centre_s > win_r[r][c]));
                is_min_s = is_min_s & ((r == 1 && c == 1) || (centre_s < win_r[r][c]));
            end
        end
        mag_s  = dog_abs(centre_s);
        cand_s = eval_r & (is_max_s | is_min_s) & (mag_s >= (DOG_W+1)'(THRESH));
    end

    assign pop_s    = ~fifo_empty_s & kp_ready;
    assign push_s   = cand_s & (~fifo_full_s | pop_s);
    assign drop_s   = cand_s & fifo_full_s & ~pop_s;
    assign wr_rec_s = '{x: KP_XW'(cx_r), y: KP_YW'(cy_r), is_min: is_min_s};

    kp_fifo #(
        .W     (KPW),
        .DEPTH (FIFO_DEPTH)
    ) u_kp_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push_s),
        .wr_data (wr_rec_s),
        .rd_en   (pop_s),
        .rd_data (rd_data_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    assign head_s = rd_data_s;

    // Per-frame statistics, error flag and completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            kp_count_r     <= 16'd0;
            overflow_cnt_r <= 8'd0;
            frame_error_r  <= 1'b0;
            frame_done_r   <= 1'b0;
        end else begin
            if ((state_r == S_IDLE) && dog_valid) begin
                kp_count_r     <= 16'd0;
                overflow_cnt_r <= 8'd0;
            end else begin
                if (cand_s && (kp_count_r != 16'hFFFF)) begin
                    kp_count_r <= kp_count_r + 16'd1;
                end
                if (drop_s && (overflow_cnt_r != 8'hFF)) begin
                    overflow_cnt_r <= overflow_cnt_r + 8'd1;
                end
            end
            if (abort_s) begin
                frame_error_r <= 1'b1;
            end
            frame_done_r <= (state_r == S_DRAIN) && (state_next_s == S_DONE);
        end
    end

    assign kp_x         = XW'(head_s.x);
    assign kp_y         = YW'(head_s.y);
    assign kp_min       = head_s.is_min;
    assign kp_valid     = ~fifo_empty_s;
    assign kp_count     = kp_count_r;
    assign overflow_cnt = overflow_cnt_r;
    assign frame_error  = frame_error_r;
    assign frame_done   = frame_done_r;

endmodule
